// File: rtl/cdc_read_sched_if.sv
// Signal bundle between the DSP-side read scheduler and its FIFO / DSP-chain environment.
// Directions in the signal names are as seen from the scheduler.
interface cdc_read_sched_if #(
    parameter int PKT_WIDTH = 16
);
    logic                 enable_i;
    logic                 fifoEmpty_i;
    logic [PKT_WIDTH-1:0] pkt_i;
    logic                 pktChanged_i;
    logic                 clrStats_i;
    logic                 rdEN_o;
    logic [PKT_WIDTH-1:0] sample_o;
    logic                 sampleValid_o;
    logic                 underrun_o;
    logic [7:0]           underrunCnt_o;
    logic                 busy_o;

    modport master (
        input  enable_i, fifoEmpty_i, pkt_i, pktChanged_i, clrStats_i,
        output rdEN_o, sample_o, sampleValid_o, underrun_o, underrunCnt_o, busy_o
    );

    modport slave (
        output enable_i, fifoEmpty_i, pkt_i, pktChanged_i, clrStats_i,
        input  rdEN_o, sample_o, sampleValid_o, underrun_o, underrunCnt_o, busy_o
    );
endinterface

// File: rtl/cdc_read_sched.sv
// Sample-rate read scheduler for the DSP side of the I2S-to-DSP CDC FIFO, with underrun fill.
// Build option CDC_SCHED_HOLD_EN: hold the last sample on underrun; undefined inserts silence.
module cdc_read_sched #(
    parameter int PKT_WIDTH  = 16,
    parameter int DIV        = 136,
    parameter int RD_TIMEOUT = 3
) (
    input  logic             clkDSP_i,
    input  logic             rstDSP_i,
    cdc_read_sched_if.master bus
);
    localparam int                WAIT_W    = $clog2(RD_TIMEOUT + 1) + 1;
    localparam logic [15:0]       TICK_LAST = 16'(DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_TIMEOUT);
`ifdef CDC_SCHED_HOLD_EN
    localparam logic HOLD_FILL = 1'b1;
`else
    localparam logic HOLD_FILL = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, PRIME, RUN, READ} state_t;

    state_t               state_q, state_d;
    logic [15:0]          tick_cnt_q, tick_cnt_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 ever_ok_q, ever_ok_d;
    logic                 rd_en_q, rd_en_d;
    logic [PKT_WIDTH-1:0] sample_q, sample_d;
    logic                 valid_q, valid_d;
    logic                 underrun_q, underrun_d;
    logic [7:0]           und_cnt_q, und_cnt_d;
    logic                 tick;
    logic                 cnt_up;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [PKT_WIDTH-1:0] fill_sample(input logic [PKT_WIDTH-1:0] prev);
        return HOLD_FILL ? prev : '0;
    endfunction

    // Gating with enable_i keeps a stale terminal count from firing on the cycle enable drops.
    assign tick = bus.enable_i && (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        ever_ok_d  = ever_ok_q;
        rd_en_d    = 1'b0;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        underrun_d = 1'b0;
        cnt_up     = 1'b0;
        tick_cnt_d = '0;
        if (bus.enable_i) begin
            tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                ever_ok_d = 1'b0;
                if (bus.enable_i) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (!bus.enable_i) begin
                    state_d = IDLE;
                end else if (tick && !bus.fifoEmpty_i) begin
                    state_d = READ;
                    rd_en_d = 1'b1;
                    wait_d  = '0;
                end
            end
            RUN: begin
                if (!bus.enable_i) begin
                    state_d = IDLE;
                end else if (tick && !bus.fifoEmpty_i) begin
                    state_d = READ;
                    rd_en_d = 1'b1;
                    wait_d  = '0;
                end else if (tick) begin
                    underrun_d = 1'b1;
                    valid_d    = 1'b1;
                    sample_d   = fill_sample(sample_q);
                    cnt_up     = 1'b1;
                end
            end
            READ: begin
                // A read in flight always finishes; a dropped enable only redirects the exit.
                if (bus.pktChanged_i) begin
                    sample_d  = bus.pkt_i;
                    valid_d   = 1'b1;
                    ever_ok_d = 1'b1;
                    state_d   = bus.enable_i ? RUN : IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    underrun_d = 1'b1;
                    if (ever_ok_q) begin
                        valid_d  = 1'b1;
                        sample_d = fill_sample(sample_q);
                        cnt_up   = 1'b1;
                    end
                    if (!bus.enable_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ever_ok_q ? RUN : PRIME;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        und_cnt_d = und_cnt_q;
        if (bus.clrStats_i) begin
            und_cnt_d = 8'd0;
        end else if (cnt_up) begin
            und_cnt_d = sat_inc(und_cnt_q);
        end
    end

    always_ff @(posedge clkDSP_i or posedge rstDSP_i) begin
        if (rstDSP_i) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            wait_q     <= '0;
            ever_ok_q  <= 1'b0;
            rd_en_q    <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
            und_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            wait_q     <= wait_d;
            ever_ok_q  <= ever_ok_d;
            rd_en_q    <= rd_en_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
            und_cnt_q  <= und_cnt_d;
        end
    end

    assign bus.rdEN_o        = rd_en_q;
    assign bus.sample_o      = sample_q;
    assign bus.sampleValid_o = valid_q;
    assign bus.underrun_o    = underrun_q;
    assign bus.underrunCnt_o = und_cnt_q;
    assign bus.busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_cdc_read_sched.sv
// Scoreboard bench for cdc_read_sched: DIV=8, RD_TIMEOUT=3, FIFO model answering one cycle after rdEN_o.
module tb_cdc_read_sched;
    localparam int W = 16;
`ifdef CDC_SCHED_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] data;
        logic         und;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    exp_t         expq[$];
    logic [W-1:0] fq[$];
    bit           stall = 1'b0;
    bit           man = 1'b0;
    int           rd_cnt = 0, und_cnt = 0, val_cnt = 0;
    int           rd_cyc = 0, und_cyc = 0;
    int           val_cyc[$];

    cdc_read_sched_if #(.PKT_WIDTH(W)) bus ();

    cdc_read_sched #(.PKT_WIDTH(W), .DIV(8), .RD_TIMEOUT(3)) dut (
        .clkDSP_i (clk),
        .rstDSP_i (rst),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    function automatic logic [W-1:0] fill_exp(input logic [W-1:0] last);
        return HOLD ? last : '0;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_fifo(input logic [W-1:0] v);
        fq.push_back(v);
        expq.push_back('{data: v, und: 1'b0});
    endtask

    task automatic push_und(input logic [W-1:0] last);
        expq.push_back('{data: fill_exp(last), und: 1'b1});
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(tag, expq.size(), 0);
        expq.delete();
    endtask

    task automatic wait_rd(input string tag, input int target, input int budget);
        int n = 0;
        while (rd_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(rd_cnt >= target), 1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // FIFO model: data appears with pktChanged_i the cycle after rdEN_o is seen.
    initial begin
        logic rd_seen;
        forever begin
            @(negedge clk);
            rd_seen = bus.rdEN_o;
            @(posedge clk);
            #1;
            if (!man) begin
                if (!stall && rd_seen && fq.size() != 0) begin
                    bus.pkt_i        = fq.pop_front();
                    bus.pktChanged_i = 1'b1;
                end else begin
                    bus.pktChanged_i = 1'b0;
                end
                bus.fifoEmpty_i = stall ? 1'b0 : (fq.size() == 0);
            end
        end
    end

    // Output monitor: every sample strobe is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.rdEN_o) begin rd_cnt++; rd_cyc = cyc; end
                if (bus.underrun_o) begin und_cnt++; und_cyc = cyc; end
                if (bus.sampleValid_o) begin
                    val_cnt++;
                    val_cyc.push_back(cyc);
                    if (expq.size() == 0) begin
                        chk("unexpected_valid", {16'h0, bus.sample_o}, 32'hFFFF_FFFF);
                    end else begin
                        e = expq.pop_front();
                        chk("sample", {16'h0, bus.sample_o}, {16'h0, e.data});
                        chk("underrun_flag", {31'h0, bus.underrun_o}, {31'h0, e.und});
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c, r1, vi, u0, v0, rd0;
        bus.enable_i     = 1'b0;
        bus.fifoEmpty_i  = 1'b1;
        bus.pkt_i        = '0;
        bus.pktChanged_i = 1'b0;
        bus.clrStats_i   = 1'b0;
        step();
        step();
        chk("rst_rdEN", bus.rdEN_o, 0);
        chk("rst_sample", bus.sample_o, 0);
        chk("rst_valid", bus.sampleValid_o, 0);
        chk("rst_underrun", bus.underrun_o, 0);
        chk("rst_cnt", bus.underrunCnt_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        rst = 1'b0;
        step();

        // Two back-to-back reads one sample period apart.
        push_fifo(16'h1111);
        push_fifo(16'h2222);
        step();
        step();
        bus.enable_i = 1'b1;
        c  = cyc;
        vi = val_cyc.size();
        wait_rd("first_rd", 1, 20);
        r1 = rd_cyc;
        chk("rd_after_tick", r1 - c, 8);
        wait_drain("p1_drain", 30);
        bus.enable_i = 1'b0;
        chk("tick_to_valid", val_cyc[vi] - r1, 2);
        chk("valid_spacing", val_cyc[vi+1] - val_cyc[vi], 8);
        chk("p1_cnt", bus.underrunCnt_o, 0);
        step();
        step();
        chk("p1_idle", bus.busy_o, 0);

        // Three empty ticks after priming.
        do_reset();
        push_fifo(16'hABCD);
        push_und(16'hABCD);
        push_und(16'hABCD);
        push_und(16'hABCD);
        step();
        step();
        u0 = und_cnt;
        bus.enable_i = 1'b1;
        wait_drain("p2_drain", 60);
        bus.enable_i = 1'b0;
        step();
        chk("p2_und_pulses", und_cnt - u0, 3);
        chk("p2_cnt", bus.underrunCnt_o, 3);
        chk("p2_fill", bus.sample_o, fill_exp(16'hABCD));

        // Read timeout before any success, then after a success.
        do_reset();
        stall = 1'b1;
        step();
        step();
        u0 = und_cnt;
        v0 = val_cnt;
        rd0 = rd_cnt;
        bus.enable_i = 1'b1;
        wait_rd("p3_rd", rd0 + 1, 20);
        r1 = rd_cyc;
        begin
            int n = 0;
            while (und_cnt == u0 && n < 20) begin step(); n++; end
        end
        chk("p3_timeout_seen", und_cnt - u0, 1);
        chk("p3_timeout_lat", und_cyc - r1, 4);
        chk("p3_no_valid", val_cnt - v0, 0);
        chk("p3_cnt_prime", bus.underrunCnt_o, 0);
        chk("p3_busy", bus.busy_o, 1);
        chk("p3_single_rd", rd_cnt - rd0, 1);
        push_fifo(16'h7777);
        stall = 1'b0;
        wait_rd("p3_rd2", rd0 + 2, 20);
        chk("p3_next_rd_tick", rd_cyc - r1, 8);
        wait_drain("p3_ok_drain", 10);
        stall = 1'b1;
        push_und(16'h7777);
        wait_drain("p3_run_timeout", 30);
        bus.enable_i = 1'b0;
        step();
        chk("p3_cnt_run", bus.underrunCnt_o, 1);
        stall = 1'b0;

        // Counter saturation and clear coincident with an underrun.
        do_reset();
        push_fifo(16'h0042);
        for (int i = 0; i < 300; i++) push_und(16'h0042);
        step();
        step();
        bus.enable_i = 1'b1;
        c  = cyc;
        u0 = und_cnt;
        wait_drain("p4_drain", 2600);
        chk("p4_saturated", bus.underrunCnt_o, 255);
        push_und(16'h0042);
        wait_cyc(c + 2415);
        chk("p4_clr_align", cyc, c + 2415);
        bus.clrStats_i = 1'b1;
        step();
        bus.clrStats_i = 1'b0;
        chk("p4_clr_wins", bus.underrunCnt_o, 0);
        chk("p4_und_total", und_cnt - u0, 301);
        bus.enable_i = 1'b0;
        wait_drain("p4_last", 5);

        // Enable dropped while a read is in flight.
        do_reset();
        push_fifo(16'h5A5A);
        step();
        step();
        rd0 = rd_cnt;
        v0  = val_cnt;
        bus.enable_i = 1'b1;
        wait_rd("p5_rd", rd0 + 1, 20);
        bus.enable_i = 1'b0;
        repeat (50) step();
        chk("p5_rd_once", rd_cnt - rd0, 1);
        chk("p5_valid_once", val_cnt - v0, 1);
        chk("p5_sample", bus.sample_o, 16'h5A5A);
        chk("p5_idle", bus.busy_o, 0);
        wait_drain("p5_drain", 2);

        // Reset between rdEN_o and the returning packet.
        man = 1'b1;
        bus.fifoEmpty_i  = 1'b0;
        bus.pktChanged_i = 1'b0;
        rd0 = rd_cnt;
        bus.enable_i = 1'b1;
        wait_rd("p6_rd", rd0 + 1, 20);
        rst = 1'b1;
        step();
        chk("p6_rst_rdEN", bus.rdEN_o, 0);
        chk("p6_rst_sample", bus.sample_o, 0);
        chk("p6_rst_valid", bus.sampleValid_o, 0);
        chk("p6_rst_underrun", bus.underrun_o, 0);
        chk("p6_rst_cnt", bus.underrunCnt_o, 0);
        chk("p6_rst_busy", bus.busy_o, 0);
        rst = 1'b0;
        v0 = val_cnt;
        step();
        bus.pkt_i        = 16'hBEEF;
        bus.pktChanged_i = 1'b1;
        step();
        bus.pktChanged_i = 1'b0;
        step();
        bus.enable_i = 1'b0;
        step();
        chk("p6_late_ignored", bus.sample_o, 0);
        chk("p6_no_valid", val_cnt - v0, 0);
        man = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cdc_read_sched.md
# cdc_read_sched

Sample-rate read scheduler for the DSP-side port of the I2S-to-DSP CDC FIFO. It divides the DSP clock down to the audio sample rate and issues one read-enable per sample period. It captures the returned packet and presents one sample strobe per period to the DSP chain. It also tracks FIFO underruns and covers gaps by repeating the last sample or inserting silence.

## Interface
Parameters:
- PKT_WIDTH, 16, sample width in bits
- DIV, 136, DSP clocks per sample period; 6 MHz / 44.1 kHz rounded; legal range 8..65535
- RD_TIMEOUT, 3, max cycles from rdEN_o to pktChanged_i before the read counts as failed; must satisfy DIV > RD_TIMEOUT + 2

Ports:
- clkDSP_i  in  1  DSP clock
- rstDSP_i  in  1  asynchronous, active-high reset
- enable_i  in  1  run enable; low holds the divider and stops reads
- fifoEmpty_i  in  1  FIFO read-side empty flag, synchronous to clkDSP_i
- pkt_i  in  PKT_WIDTH  FIFO read data
- pktChanged_i  in  1  FIFO read-data-valid pulse
- clrStats_i  in  1  synchronous clear of underrun counter
- rdEN_o  out  1  FIFO read enable, one-cycle pulse
- sample_o  out  PKT_WIDTH  registered output sample
- sampleValid_o  out  1  one-cycle strobe, once per sample period while running
- underrun_o  out  1  one-cycle pulse on each underrun
- underrunCnt_o  out  8  saturating underrun count
- busy_o  out  1  high outside IDLE

## Operation
- Divider: counter tickCnt runs 0..DIV-1 and wraps while enable_i=1. tick = (tickCnt==DIV-1). When enable_i=0, tickCnt is forced to 0.
- FSM states:
  - IDLE: wait for enable_i=1, then go to PRIME.
  - PRIME: at each tick with fifoEmpty_i=0, go to READ. Before the first successful read, no sampleValid_o and no underrun counting.
  - RUN: at tick with fifoEmpty_i=0, go to READ. At tick with fifoEmpty_i=1, signal an underrun and stay in RUN.
  - READ: rdEN_o was asserted for exactly one cycle on entry. Wait for pktChanged_i.
    - On pktChanged_i: sample_o <= pkt_i; pulse sampleValid_o; go to RUN.
    - If pktChanged_i has not arrived after RD_TIMEOUT cycles: signal an underrun; go to RUN, or back to PRIME if no read has ever succeeded.
- Underrun: pulse underrun_o and sampleValid_o. Apply the fill policy to sample_o (see Configuration). underrunCnt_o increments and saturates at 255.
- enable_i falling:
  - A READ in progress completes or times out normally.
  - The FSM then goes to IDLE. No further rdEN_o.
  - sample_o holds its value.
- clrStats_i: zeroes underrunCnt_o next cycle. If an underrun occurs in the same cycle, the clear wins and the count ends at 0.
- pktChanged_i outside READ is ignored. It does not update sample_o.

## Timing
- Reset values: rdEN_o=0, sample_o=0, sampleValid_o=0, underrun_o=0, underrunCnt_o=0, busy_o=0, state IDLE, tickCnt=0.
- rdEN_o is registered and asserts the cycle after tick.
- sampleValid_o asserts the cycle after pktChanged_i is sampled high.
- With a FIFO that returns data one cycle after rdEN_o, latency is 3 cycles from tick to sampleValid_o.
- Underrun paths:
  - Empty at tick: sampleValid_o and underrun_o pulse 1 cycle after tick.
  - Timeout: both pulse the cycle after the RD_TIMEOUT-th wait cycle.
- At most one rdEN_o and one sampleValid_o per DIV cycles.
- Reset asserted mid-READ returns everything to reset values immediately. A late pktChanged_i after deassertion is ignored.

## Configuration
- CDC_SCHED_HOLD_EN defined: on underrun, sample_o keeps its previous value (sample-and-hold).
- CDC_SCHED_HOLD_EN undefined: on underrun, sample_o is set to 0 (silence insertion).
- All other behaviour is identical in both builds.

## Test plan
Bench settings: DIV=8, RD_TIMEOUT=3, FIFO model returns data 1 cycle after rdEN_o.
- Reset then enable_i=1, FIFO preloaded with 0x1111, 0x2222 -> rdEN_o one cycle after each tick; sample_o=0x1111 then 0x2222, exactly 8 cycles apart; underrunCnt_o=0.
- FIFO empty for 3 ticks after priming with 0xABCD -> 3 underrun_o pulses; underrunCnt_o=3; sample_o stays 0xABCD with HOLD_EN, 0x0000 without.
- fifoEmpty_i=0 but pktChanged_i never asserted -> timeout 3 cycles after rdEN_o; underrun_o pulses; FSM returns to PRIME if no prior success; no second rdEN_o before the next tick.
- 300 consecutive empty ticks in RUN -> underrunCnt_o saturates at 255; clrStats_i pulse coincident with an underrun -> count 0.
- enable_i dropped during READ, then data returns 0x5A5A -> sample_o=0x5A5A, sampleValid_o pulses once, FSM reaches IDLE, no further rdEN_o over 50 cycles.
- rstDSP_i asserted between rdEN_o and pktChanged_i -> all outputs 0 while reset is high; the late pktChanged_i is ignored.
